hv_cosine_mac_stream: RTL and testbench
=======================================

// Module: hv_cosine_mac_stream
// PURPOSE
//  Multi-lane streaming front end for HDC cosine similarity. Per vector pair it accumulates the integer dot products A.B, A.A and B.B over LANES elements per beat.
//  Presents the three sums with a valid/ready handshake to the downstream normalise/divide stage.
//  Generalises the scalar FP MAC engine: parallel lanes, A and B on one beat, lane masking, back-pressure, overflow reporting.
// PARAMETERS
//  LANES       8      elements of A and of B per input beat
//  ELEM_WIDTH  16     signed two's-complement element width
//  MAX_ELEMS   10240  max elements per vector; sizes accumulators
//  ACC_WIDTH   2*ELEM_WIDTH+$clog2(MAX_ELEMS)  accumulator/result width (derived, do not override)
// PORTS
//  clk           in   1                 rising-edge clock
//  reset         in   1                 asynchronous, active-high reset
//  in_valid      in   1                 input beat valid
//  in_ready      out  1                 engine can accept a beat
//  in_first      in   1                 beat is the first of a vector pair
//  in_last       in   1                 beat is the last of a vector pair
//  in_mask       in   LANES             lane enable; 0 = lane contributes zero
//  in_a          in   LANES*ELEM_WIDTH  A elements, lane 0 at LSBs
//  in_b          in   LANES*ELEM_WIDTH  B elements, lane 0 at LSBs
//  out_valid     out  1                 result valid, held until accepted
//  out_ready     in   1                 downstream accepts result
//  out_ab        out  ACC_WIDTH         signed sum A*B
//  out_aa        out  ACC_WIDTH         unsigned sum A*A
//  out_bb        out  ACC_WIDTH         unsigned sum B*B
//  out_overflow  out  1                 some accumulator exceeded range for this vector
//  err_seq       out  1                 1-cycle pulse: sequencing error
// BEHAVIOUR
//  Reset: in_ready=0, out_valid=0, out_ab/aa/bb=0, out_overflow=0, err_seq=0, FSM=IDLE. in_ready goes to 1 on the first clk after reset deasserts.
//  A beat is accepted when in_valid&&in_ready. Pipeline: P1 lane products, P2 adder tree, P3 accumulate. Fixed latency 3.
//  FSM: IDLE -> ACCUM on an accepted in_first. ACCUM -> DRAIN on an accepted in_last. DRAIN (2 cycles) -> RESULT. RESULT -> IDLE on out_valid&&out_ready.
//  in_first&&in_last on one beat is a single-beat vector: straight to DRAIN.
//  The in_first beat loads the accumulators with its own products (no clear cycle).
//  Last beat accepted at cycle T: out_valid=1 at T+3. out_* stable while out_valid&&!out_ready.
//  in_ready=1 in IDLE and ACCUM only; 0 in DRAIN and RESULT. Rises the cycle after the result handshake.
//  Gaps (in_valid=0) in ACCUM allowed; the pipeline only advances accepted data.
//  Accepted beat in IDLE without in_first: discarded, err_seq pulses.
//  in_first in ACCUM: current vector abandoned and restarted with this beat, err_seq pulses.
//  Masked lanes add 0 to all three sums, including a fully masked beat.
//  Overflow, wrap build: sums wrap modulo 2^ACC_WIDTH; out_overflow is sticky per vector and clears on in_first.
//  Reset mid-operation: pipeline, accumulators and any pending result are discarded.
// CONFIGURATION
//  HV_COSSIM_SATURATE_EN defined: each accumulator clamps at its bound (AB signed min/max, AA/BB unsigned max). out_overflow still flags the clamp.
//  HV_COSSIM_SATURATE_EN undefined: accumulators wrap modulo 2^ACC_WIDTH.
// STRUCTURE
//  Package hv_similarity_pkg holds:
//   - cossim_mac_state_t enum {IDLE, ACCUM, DRAIN, RESULT}
//   - MAC_LATENCY=3
//   - acc_width(elem_w, max_elems) function
//  Sub-module hv_lane_mac: per-lane masked products plus a registered adder tree (stages P1-P2), returning the beat sums ab/aa/bb.
//  The top level holds the FSM, the P3 accumulators, the overflow logic and the output register.
// TESTING  (LANES=4, ELEM_WIDTH=8 unless noted)
//  1 Single beat, first+last, A=[1,2,3,4], B=[4,3,2,1], mask=F -> AB=20, AA=30, BB=30, out_valid at T+3.
//  2 Three beats, gaps between, each A=B=[-1,-1,-1,-1] -> AB=AA=BB=12. out_ready low 5 cycles: outputs stable, in_ready=0.
//  3 mask=4'b0011 on last beat, A=B=[5,5,5,5] (2 beats) -> AA=BB=AB=75.
//  4 Beat without first in IDLE -> err_seq pulses, no out_valid. in_first mid-vector -> restart, result covers only the new vector.
//  5 ELEM_WIDTH=8, MAX_ELEMS=4 (ACC_WIDTH=18), 512 beats of -128 -> out_overflow=1. Wrap build: AA=(512*4*16384) mod 2^18. SATURATE_EN build: AA=2^18-1.
//  6 reset asserted in DRAIN -> out_valid stays 0. Next vector after reset gives a fresh correct result.

Source files
------------

// File: rtl/hv_cosine_mac_stream_pkg.sv
// ---------------------------------------------------------------------------
// hv_similarity_pkg
// Shared types and constants for the HDC cosine-similarity MAC front end.
//   cossim_mac_state_t : control FSM states of hv_cosine_mac_stream
//   MAC_LATENCY        : accepted last beat to out_valid, in clocks
//   acc_width()        : accumulator width for a given element width and
//                        maximum vector length
// ---------------------------------------------------------------------------
package hv_similarity_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN,
      RESULT
   } cossim_mac_state_t;

   // Lane products (P1), beat adder tree (P2), accumulate (P3).
   localparam int MAC_LATENCY = 3;

   // Worst-case sum of max_elems products of two elem_w-bit signed values.
   function automatic int acc_width(input int elem_w, input int max_elems);
      return 2 * elem_w + $clog2(max_elems);
   endfunction

endpackage

// File: rtl/hv_cosine_mac_stream_if.sv
// ---------------------------------------------------------------------------
// hv_cosine_mac_stream_if
// Input beat stream and result stream of the cosine MAC engine.
//   in_valid/in_ready      : beat handshake
//   in_first/in_last       : vector-pair framing
//   in_mask                : per-lane enable
//   in_a/in_b              : LANES elements each, lane 0 at the LSBs
//   out_valid/out_ready    : result handshake
//   out_ab                 : signed sum A*B (two's complement bits)
//   out_aa/out_bb          : unsigned sums A*A and B*B
//   out_overflow           : accumulator range exceeded for this vector
//   err_seq                : one-cycle sequencing error pulse
// Modports: slave = engine side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface hv_cosine_mac_stream_if
   import hv_similarity_pkg::*;
#(
   parameter int LANES      = 8,
   parameter int ELEM_WIDTH = 16,
   parameter int ACC_WIDTH  = acc_width(16, 10240)
);

   logic                          in_valid;
   logic                          in_ready;
   logic                          in_first;
   logic                          in_last;
   logic [LANES-1:0]              in_mask;
   logic [LANES*ELEM_WIDTH-1:0]   in_a;
   logic [LANES*ELEM_WIDTH-1:0]   in_b;
   logic                          out_valid;
   logic                          out_ready;
   logic [ACC_WIDTH-1:0]          out_ab;
   logic [ACC_WIDTH-1:0]          out_aa;
   logic [ACC_WIDTH-1:0]          out_bb;
   logic                          out_overflow;
   logic                          err_seq;

   modport slave (
      input  in_valid, in_first, in_last, in_mask, in_a, in_b, out_ready,
      output in_ready, out_valid, out_ab, out_aa, out_bb, out_overflow, err_seq
   );

   modport master (
      output in_valid, in_first, in_last, in_mask, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_ab, out_aa, out_bb, out_overflow, err_seq
   );

endinterface

// File: rtl/hv_cosine_mac_stream_lane_mac.sv
// ---------------------------------------------------------------------------
// hv_lane_mac
// Per-lane masked products (P1) followed by a registered reduction of the
// lanes (P2). Produces the A.B, A.A and B.B contributions of one beat.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid              : beat enters the pipeline this cycle
//   in_first/in_last      : framing tags carried alongside the data
//   in_mask, in_a, in_b   : lane enables and packed elements
//   out_valid/first/last  : tags of the beat sums now presented
//   out_ab/out_aa/out_bb  : signed beat sums (aa/bb are never negative)
// ---------------------------------------------------------------------------
module hv_lane_mac
   import hv_similarity_pkg::*;
#(
   parameter int LANES      = 8,
   parameter int ELEM_WIDTH = 16,
   parameter int SUM_WIDTH  = 2 * ELEM_WIDTH + $clog2(LANES) + 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   input  logic                              in_first,
   input  logic                              in_last,
   input  logic [LANES-1:0]                  in_mask,
   input  logic [LANES*ELEM_WIDTH-1:0]       in_a,
   input  logic [LANES*ELEM_WIDTH-1:0]       in_b,
   output logic                              out_valid,
   output logic                              out_first,
   output logic                              out_last,
   output logic signed [SUM_WIDTH-1:0]       out_ab,
   output logic signed [SUM_WIDTH-1:0]       out_aa,
   output logic signed [SUM_WIDTH-1:0]       out_bb
);

   localparam int PROD_WIDTH = 2 * ELEM_WIDTH;
   localparam int EXT_WIDTH  = SUM_WIDTH - PROD_WIDTH;

   logic signed [PROD_WIDTH-1:0] prod_ab [LANES];
   logic signed [PROD_WIDTH-1:0] prod_aa [LANES];
   logic signed [PROD_WIDTH-1:0] prod_bb [LANES];

   logic signed [PROD_WIDTH-1:0] p1_ab [LANES];
   logic signed [PROD_WIDTH-1:0] p1_aa [LANES];
   logic signed [PROD_WIDTH-1:0] p1_bb [LANES];
   logic                         p1_valid;
   logic                         p1_first;
   logic                         p1_last;

   logic signed [SUM_WIDTH-1:0]  sum_ab;
   logic signed [SUM_WIDTH-1:0]  sum_aa;
   logic signed [SUM_WIDTH-1:0]  sum_bb;

   // Elements are sign-extended to product width before multiplying so the
   // product is exact; a masked lane contributes zero to all three sums.
   always_comb begin : lane_products
      logic signed [PROD_WIDTH-1:0] a_x;
      logic signed [PROD_WIDTH-1:0] b_x;
      a_x = '0;
      b_x = '0;
      for (int l = 0; l < LANES; l++) begin
         prod_ab[l] = '0;
         prod_aa[l] = '0;
         prod_bb[l] = '0;
         a_x = {{ELEM_WIDTH{in_a[l*ELEM_WIDTH+ELEM_WIDTH-1]}},
                in_a[l*ELEM_WIDTH +: ELEM_WIDTH]};
         b_x = {{ELEM_WIDTH{in_b[l*ELEM_WIDTH+ELEM_WIDTH-1]}},
                in_b[l*ELEM_WIDTH +: ELEM_WIDTH]};
         if (in_mask[l]) begin
            prod_ab[l] = a_x * b_x;
            prod_aa[l] = a_x * a_x;
            prod_bb[l] = b_x * b_x;
         end
      end
   end

   // P1: product registers only load on an accepted beat so idle cycles do
   // not disturb the data already in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p1_valid <= 1'b0;
         p1_first <= 1'b0;
         p1_last  <= 1'b0;
         for (int l = 0; l < LANES; l++) begin
            p1_ab[l] <= '0;
            p1_aa[l] <= '0;
            p1_bb[l] <= '0;
         end
      end else begin
         p1_valid <= in_valid;
         if (in_valid) begin
            p1_first <= in_first;
            p1_last  <= in_last;
            for (int l = 0; l < LANES; l++) begin
               p1_ab[l] <= prod_ab[l];
               p1_aa[l] <= prod_aa[l];
               p1_bb[l] <= prod_bb[l];
            end
         end
      end
   end

   // Lane reduction; the extra headroom bits make the beat sum exact for
   // any LANES.
   always_comb begin : lane_reduce
      sum_ab = '0;
      sum_aa = '0;
      sum_bb = '0;
      for (int l = 0; l < LANES; l++) begin
         sum_ab = sum_ab + {{EXT_WIDTH{p1_ab[l][PROD_WIDTH-1]}}, p1_ab[l]};
         sum_aa = sum_aa + {{EXT_WIDTH{p1_aa[l][PROD_WIDTH-1]}}, p1_aa[l]};
         sum_bb = sum_bb + {{EXT_WIDTH{p1_bb[l][PROD_WIDTH-1]}}, p1_bb[l]};
      end
   end

   // P2: registered beat sums handed to the accumulator stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         out_ab    <= '0;
         out_aa    <= '0;
         out_bb    <= '0;
      end else begin
         out_valid <= p1_valid;
         if (p1_valid) begin
            out_first <= p1_first;
            out_last  <= p1_last;
            out_ab    <= sum_ab;
            out_aa    <= sum_aa;
            out_bb    <= sum_bb;
         end
      end
   end

endmodule

// File: rtl/hv_cosine_mac_stream.sv
// ---------------------------------------------------------------------------
// hv_cosine_mac_stream
// Multi-lane streaming front end for HDC cosine similarity. Accumulates
// A.B, A.A and B.B over the beats of one vector pair and presents the three
// sums to the downstream normalise/divide stage.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : hv_cosine_mac_stream_if.slave (beat input, result output,
//            overflow flag, sequencing error pulse)
// Build option:
//   HV_COSSIM_SATURATE_EN defined   -> accumulators clamp at their bounds
//   HV_COSSIM_SATURATE_EN undefined -> accumulators wrap modulo 2^ACC_WIDTH
// Result appears MAC_LATENCY clocks after the last beat is accepted.
// ---------------------------------------------------------------------------
module hv_cosine_mac_stream
   import hv_similarity_pkg::*;
#(
   parameter int LANES      = 8,
   parameter int ELEM_WIDTH = 16,
   parameter int MAX_ELEMS  = 10240
) (
   input  logic                   clk,
   input  logic                   reset,
   hv_cosine_mac_stream_if.slave  bus
);

   localparam int ACC_WIDTH  = acc_width(ELEM_WIDTH, MAX_ELEMS);
   localparam int SUM_WIDTH  = 2 * ELEM_WIDTH + $clog2(LANES) + 1;
   localparam int WIDE_WIDTH = ((ACC_WIDTH > SUM_WIDTH) ? ACC_WIDTH : SUM_WIDTH) + 2;
   localparam logic [1:0] DRAIN_LAST = 2'(MAC_LATENCY - 2);

   cossim_mac_state_t state;
   cossim_mac_state_t state_n;
   logic [1:0]        drain_cnt;
   logic              ready_en;
   logic              in_ready;
   logic              accept;
   logic              push;
   logic              err_n;
   logic              err_q;

   logic                         beat_valid;
   logic                         beat_first;
   logic                         beat_last;
   logic signed [SUM_WIDTH-1:0]  beat_ab;
   logic signed [SUM_WIDTH-1:0]  beat_aa;
   logic signed [SUM_WIDTH-1:0]  beat_bb;

   logic [ACC_WIDTH-1:0]  acc_ab;
   logic [ACC_WIDTH-1:0]  acc_aa;
   logic [ACC_WIDTH-1:0]  acc_bb;
   logic                  acc_ovf;
   logic [ACC_WIDTH-1:0]  next_ab;
   logic [ACC_WIDTH-1:0]  next_aa;
   logic [ACC_WIDTH-1:0]  next_bb;
   logic                  next_ovf;
   logic [WIDE_WIDTH-1:0] wide_ab;
   logic [WIDE_WIDTH-1:0] wide_aa;
   logic [WIDE_WIDTH-1:0] wide_bb;
   logic                  ovf_ab;
   logic                  ovf_aa;
   logic                  ovf_bb;

   logic [ACC_WIDTH-1:0]  res_ab;
   logic [ACC_WIDTH-1:0]  res_aa;
   logic [ACC_WIDTH-1:0]  res_bb;
   logic                  res_ovf;

   // ready_en keeps in_ready low through reset and for the first clock
   // after it; otherwise the engine takes beats only in IDLE and ACCUM.
   assign in_ready = ready_en && ((state == IDLE) || (state == ACCUM));
   assign accept   = bus.in_valid && in_ready;
   // A stray beat in IDLE without in_first is dropped before the pipeline.
   assign push     = accept && (bus.in_first || (state == ACCUM));

   hv_lane_mac #(
      .LANES      (LANES),
      .ELEM_WIDTH (ELEM_WIDTH),
      .SUM_WIDTH  (SUM_WIDTH)
   ) u_lane_mac (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (push),
      .in_first  (bus.in_first),
      .in_last   (bus.in_last),
      .in_mask   (bus.in_mask),
      .in_a      (bus.in_a),
      .in_b      (bus.in_b),
      .out_valid (beat_valid),
      .out_first (beat_first),
      .out_last  (beat_last),
      .out_ab    (beat_ab),
      .out_aa    (beat_aa),
      .out_bb    (beat_bb)
   );

   // State register, drain timer, ready enable and registered error pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         drain_cnt <= '0;
         ready_en  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state     <= state_n;
         drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
         ready_en  <= 1'b1;
         err_q     <= err_n;
      end
   end

   // DRAIN waits for the last beat to pass P1 and P2; the result register
   // loads on the same edge that enters RESULT. An in_first inside ACCUM
   // restarts the vector, and with in_last it is a complete vector.
   always_comb begin
      state_n = state;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bus.in_first) begin
                  state_n = bus.in_last ? DRAIN : ACCUM;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               if (bus.in_first) begin
                  err_n = 1'b1;
               end
               if (bus.in_last) begin
                  state_n = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
               state_n = RESULT;
            end
         end
         RESULT: begin
            if (bus.out_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // P3 arithmetic in a widened domain so range violations are visible.
   // A first beat starts from zero instead of the old sum, which removes the
   // need for a separate clear cycle between vectors.
   always_comb begin
      wide_ab = {{(WIDE_WIDTH-SUM_WIDTH){beat_ab[SUM_WIDTH-1]}}, beat_ab};
      wide_aa = {{(WIDE_WIDTH-SUM_WIDTH){beat_aa[SUM_WIDTH-1]}}, beat_aa};
      wide_bb = {{(WIDE_WIDTH-SUM_WIDTH){beat_bb[SUM_WIDTH-1]}}, beat_bb};
      if (!beat_first) begin
         wide_ab = wide_ab + {{(WIDE_WIDTH-ACC_WIDTH){acc_ab[ACC_WIDTH-1]}}, acc_ab};
         wide_aa = wide_aa + {{(WIDE_WIDTH-ACC_WIDTH){1'b0}}, acc_aa};
         wide_bb = wide_bb + {{(WIDE_WIDTH-ACC_WIDTH){1'b0}}, acc_bb};
      end
      ovf_ab = (wide_ab[WIDE_WIDTH-1:ACC_WIDTH-1] != '0) &&
               (wide_ab[WIDE_WIDTH-1:ACC_WIDTH-1] != '1);
      ovf_aa = (wide_aa[WIDE_WIDTH-1:ACC_WIDTH] != '0);
      ovf_bb = (wide_bb[WIDE_WIDTH-1:ACC_WIDTH] != '0);
`ifdef HV_COSSIM_SATURATE_EN
      next_ab = wide_ab[ACC_WIDTH-1:0];
      if (ovf_ab) begin
         next_ab = wide_ab[WIDE_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
      next_aa = ovf_aa ? {ACC_WIDTH{1'b1}} : wide_aa[ACC_WIDTH-1:0];
      next_bb = ovf_bb ? {ACC_WIDTH{1'b1}} : wide_bb[ACC_WIDTH-1:0];
`else
      next_ab = wide_ab[ACC_WIDTH-1:0];
      next_aa = wide_aa[ACC_WIDTH-1:0];
      next_bb = wide_bb[ACC_WIDTH-1:0];
`endif
      next_ovf = (beat_first ? 1'b0 : acc_ovf) | ovf_ab | ovf_aa | ovf_bb;
   end

   // Accumulators advance only on beats that actually reached P3.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_ab  <= '0;
         acc_aa  <= '0;
         acc_bb  <= '0;
         acc_ovf <= 1'b0;
      end else if (beat_valid) begin
         acc_ab  <= next_ab;
         acc_aa  <= next_aa;
         acc_bb  <= next_bb;
         acc_ovf <= next_ovf;
      end
   end

   // Result register captures the final sums with the last beat and then
   // holds them; nothing new can arrive until the result is taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_ab  <= '0;
         res_aa  <= '0;
         res_bb  <= '0;
         res_ovf <= 1'b0;
      end else if (beat_valid && beat_last) begin
         res_ab  <= next_ab;
         res_aa  <= next_aa;
         res_bb  <= next_bb;
         res_ovf <= next_ovf;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = (state == RESULT);
   assign bus.out_ab       = res_ab;
   assign bus.out_aa       = res_aa;
   assign bus.out_bb       = res_bb;
   assign bus.out_overflow = res_ovf;
   assign bus.err_seq      = err_q;

endmodule

// File: tb/tb_hv_cosine_mac_stream.sv
// ---------------------------------------------------------------------------
// tb_hv_cosine_mac_stream
// Directed bench for hv_cosine_mac_stream with LANES=4, ELEM_WIDTH=8,
// MAX_ELEMS=4 (ACC_WIDTH=18). Expected values are hand computed.
// Honours HV_COSSIM_SATURATE_EN for the overflow vector.
// ---------------------------------------------------------------------------
module tb_hv_cosine_mac_stream;

   logic clk = 1'b0;
   logic reset;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   hv_cosine_mac_stream_if #(.LANES(4), .ELEM_WIDTH(8), .ACC_WIDTH(18)) bus ();

   hv_cosine_mac_stream #(
      .LANES      (4),
      .ELEM_WIDTH (8),
      .MAX_ELEMS  (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
      return {e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
   endfunction

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one beat and returns 1 ns after the edge that accepted it.
   task automatic apply_stimulus(input logic first, input logic last, input logic [3:0] mask,
                                 input logic [31:0] a, input logic [31:0] b);
      logic done;
      done         = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_first = first;
      bus.in_last  = last;
      bus.in_mask  = mask;
      bus.in_a     = a;
      bus.in_b     = b;
      for (int i = 0; i < 20 && !done; i++) begin
         if (bus.in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.in_first = 1'b0;
      bus.in_last  = 1'b0;
      if (!done) check_output("accept_timeout", 64'(done), 1);
   endtask

   task automatic wait_result(input string tag);
      int n;
      n = 0;
      while (!bus.out_valid && n < 20) begin
         tick(1);
         n++;
      end
      check_output({tag, "_valid"}, 64'(bus.out_valid), 1);
   endtask

   task automatic collect(input string tag, input int ab, input int aa, input int bb, input logic ovf);
      wait_result(tag);
      check_output({tag, "_ab"}, 64'(bus.out_ab), 64'(ab));
      check_output({tag, "_aa"}, 64'(bus.out_aa), 64'(aa));
      check_output({tag, "_bb"}, 64'(bus.out_bb), 64'(bb));
      check_output({tag, "_ovf"}, 64'(bus.out_overflow), 64'(ovf));
      bus.out_ready = 1'b1;
      tick(1);
      bus.out_ready = 1'b0;
      check_output({tag, "_valid_dropped"}, 64'(bus.out_valid), 0);
      check_output({tag, "_ready_back"}, 64'(bus.in_ready), 1);
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_first  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_mask   = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      $display("[TB] reset state");
      tick(3);
      check_output("rst_in_ready", 64'(bus.in_ready), 0);
      check_output("rst_out_valid", 64'(bus.out_valid), 0);
      check_output("rst_out_ab", 64'(bus.out_ab), 0);
      check_output("rst_out_aa", 64'(bus.out_aa), 0);
      check_output("rst_out_bb", 64'(bus.out_bb), 0);
      check_output("rst_out_ovf", 64'(bus.out_overflow), 0);
      check_output("rst_err_seq", 64'(bus.err_seq), 0);
      reset = 1'b0;
      check_output("rel_in_ready_low", 64'(bus.in_ready), 0);
      tick(1);
      check_output("rel_in_ready_high", 64'(bus.in_ready), 1);

      $display("[TB] single beat vector and latency");
      apply_stimulus(1'b1, 1'b1, 4'hF, pack4(1, 2, 3, 4), pack4(4, 3, 2, 1));
      check_output("t1_valid_k0", 64'(bus.out_valid), 0);
      check_output("t1_ready_drain", 64'(bus.in_ready), 0);
      tick(1);
      check_output("t1_valid_k1", 64'(bus.out_valid), 0);
      tick(1);
      check_output("t1_valid_k2", 64'(bus.out_valid), 1);
      collect("t1", 20, 30, 30, 1'b0);

      $display("[TB] gapped beats and back-pressure");
      apply_stimulus(1'b1, 1'b0, 4'hF, pack4(-1, -1, -1, -1), pack4(-1, -1, -1, -1));
      tick(2);
      apply_stimulus(1'b0, 1'b0, 4'hF, pack4(-1, -1, -1, -1), pack4(-1, -1, -1, -1));
      tick(3);
      apply_stimulus(1'b0, 1'b1, 4'hF, pack4(-1, -1, -1, -1), pack4(-1, -1, -1, -1));
      wait_result("t2_stall");
      for (int c = 0; c < 5; c++) begin
         check_output("t2_hold_valid", 64'(bus.out_valid), 1);
         check_output("t2_hold_ab", 64'(bus.out_ab), 12);
         check_output("t2_hold_aa", 64'(bus.out_aa), 12);
         check_output("t2_hold_bb", 64'(bus.out_bb), 12);
         check_output("t2_hold_ready", 64'(bus.in_ready), 0);
         tick(1);
      end
      collect("t2", 12, 12, 12, 1'b0);

      $display("[TB] lane masking");
      apply_stimulus(1'b1, 1'b0, 4'b0001, pack4(5, 5, 5, 5), pack4(5, 5, 5, 5));
      apply_stimulus(1'b0, 1'b1, 4'b0011, pack4(5, 5, 5, 5), pack4(5, 5, 5, 5));
      collect("t3", 75, 75, 75, 1'b0);
      apply_stimulus(1'b1, 1'b1, 4'b0000, pack4(7, 7, 7, 7), pack4(3, 3, 3, 3));
      collect("t3_allmask", 0, 0, 0, 1'b0);

      $display("[TB] sequencing errors");
      apply_stimulus(1'b0, 1'b1, 4'hF, pack4(9, 9, 9, 9), pack4(9, 9, 9, 9));
      check_output("t4_stray_err", 64'(bus.err_seq), 1);
      tick(1);
      check_output("t4_stray_err_clear", 64'(bus.err_seq), 0);
      tick(4);
      check_output("t4_stray_no_valid", 64'(bus.out_valid), 0);
      check_output("t4_stray_ready", 64'(bus.in_ready), 1);
      apply_stimulus(1'b1, 1'b0, 4'hF, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
      check_output("t4_first_no_err", 64'(bus.err_seq), 0);
      apply_stimulus(1'b0, 1'b0, 4'hF, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
      apply_stimulus(1'b1, 1'b0, 4'hF, pack4(2, 2, 2, 2), pack4(3, 3, 3, 3));
      check_output("t4_restart_err", 64'(bus.err_seq), 1);
      apply_stimulus(1'b0, 1'b1, 4'hF, pack4(1, 0, 0, 0), pack4(1, 0, 0, 0));
      collect("t4", 25, 17, 37, 1'b0);

      $display("[TB] accumulator overflow");
      for (int i = 0; i < 512; i++) begin
         apply_stimulus(i == 0, i == 511, 4'hF, pack4(-128, -128, -128, -128),
                        pack4(-128, -128, -128, -128));
      end
`ifdef HV_COSSIM_SATURATE_EN
      collect("t5", 131071, 262143, 262143, 1'b1);
`else
      collect("t5", 0, 0, 0, 1'b1);
`endif

      $display("[TB] reset during drain");
      apply_stimulus(1'b1, 1'b1, 4'hF, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2));
      reset = 1'b1;
      check_output("t6_rst_valid", 64'(bus.out_valid), 0);
      check_output("t6_rst_ready", 64'(bus.in_ready), 0);
      tick(2);
      reset = 1'b0;
      check_output("t6_rel_ab", 64'(bus.out_ab), 0);
      check_output("t6_rel_ovf", 64'(bus.out_overflow), 0);
      tick(4);
      check_output("t6_no_valid", 64'(bus.out_valid), 0);
      apply_stimulus(1'b1, 1'b1, 4'hF, pack4(2, -3, 4, 1), pack4(3, -2, 1, 5));
      collect("t6", 21, 30, 39, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
